// File: rtl/mult_div_pkg.sv
// Shared constants, op encodings and FSM state codes for the HI/LO multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned MD_WIDTH   = 32;
    localparam int unsigned ITER_COUNT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef logic [1:0] mdState_t;
    localparam mdState_t IDLE = 2'd0;
    localparam mdState_t ITER = 2'd1;
    localparam mdState_t FIX  = 2'd2;

    function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] x,
                                                      input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide on
// unsigned magnitudes, with sign correction applied in a final FIX cycle.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [2:0]          Op,
    input  logic [MD_WIDTH-1:0] OperandA,
    input  logic [MD_WIDTH-1:0] OperandB,
    output logic                Busy,
    output logic                Done,
    output logic [MD_WIDTH-1:0] Hi,
    output logic [MD_WIDTH-1:0] Lo
);

    localparam logic [5:0] LAST_STEP = 6'(ITER_COUNT - 1);

    mdState_t              state, stateNext;
    logic [5:0]            count;
    logic [2*MD_WIDTH-1:0] acc;
    logic [MD_WIDTH-1:0]   opB;
    logic                  isDiv, negA, negB, divZero;

    logic                  signedOp;
    logic [MD_WIDTH-1:0]   magA, magB;
    logic [MD_WIDTH:0]     mulSum;
    logic [2*MD_WIDTH-1:0] mulStep;
    logic [MD_WIDTH:0]     divShift;
    logic [MD_WIDTH+1:0]   divDiff;
    logic [2*MD_WIDTH-1:0] divStep;
    logic [2*MD_WIDTH-1:0] prodOut;
    logic [MD_WIDTH-1:0]   fixHi, fixLo;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (Start && (Op <= OP_DIVU)) stateNext = ITER;
            ITER: if (count == LAST_STEP) stateNext = FIX;
            FIX:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        signedOp = (Op == OP_MULT) || (Op == OP_DIV);
        magA     = magnitude(OperandA, signedOp & OperandA[MD_WIDTH-1]);
        magB     = magnitude(OperandB, signedOp & OperandB[MD_WIDTH-1]);

        // Multiply: acc = {partial product, remaining multiplier bits}
        mulSum   = {1'b0, acc[2*MD_WIDTH-1:MD_WIDTH]} + {1'b0, opB};
        mulStep  = acc[0] ? {mulSum, acc[MD_WIDTH-1:1]} : {1'b0, acc[2*MD_WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits shifting into quotient}
        divShift = {acc[2*MD_WIDTH-1:MD_WIDTH], acc[MD_WIDTH-1]};
        divDiff  = {1'b0, divShift} - {2'b0, opB};
        divStep  = divDiff[MD_WIDTH+1]
                 ? {divShift[MD_WIDTH-1:0], acc[MD_WIDTH-2:0], 1'b0}
                 : {divDiff[MD_WIDTH-1:0], acc[MD_WIDTH-2:0], 1'b1};

        prodOut  = (negA ^ negB) ? (~acc + 64'd1) : acc;
        if (isDiv) begin
            fixHi = magnitude(acc[2*MD_WIDTH-1:MD_WIDTH], negA);
            fixLo = divZero ? '1 : magnitude(acc[MD_WIDTH-1:0], negA ^ negB);
        end else begin
            fixHi = prodOut[2*MD_WIDTH-1:MD_WIDTH];
            fixLo = prodOut[MD_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            opB     <= '0;
            isDiv   <= 1'b0;
            negA    <= 1'b0;
            negB    <= 1'b0;
            divZero <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            state <= stateNext;
            Done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MULT, OP_MULTU: begin
                                acc     <= {{MD_WIDTH{1'b0}}, magB};
                                opB     <= magA;
                                isDiv   <= 1'b0;
                                divZero <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {{MD_WIDTH{1'b0}}, magA};
                                opB     <= magB;
                                isDiv   <= 1'b1;
                                divZero <= (OperandB == '0);
                            end
                            OP_MTHI: Hi <= OperandA;
                            OP_MTLO: Lo <= OperandA;
                            default: ;
                        endcase
                        if (Op <= OP_DIVU) begin
                            negA  <= signedOp & OperandA[MD_WIDTH-1];
                            negB  <= signedOp & OperandB[MD_WIDTH-1];
                            count <= '0;
                            Busy  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc   <= isDiv ? divStep : mulStep;
                    count <= count + 6'd1;
                end
                FIX: begin
                    Hi   <= fixHi;
                    Lo   <= fixLo;
                    Done <= 1'b1;
                    Busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
